fft_core_arbiter: RTL and testbench

- Shares one forward/inverse FFT core (8-bit config AXI-stream, 48-bit data in, 64-bit data out) between two requesters: port 0 issues forward transforms, port 1 issues inverse transforms, as used by the convolution pipeline.
- Each granted frame is sequenced as: issue a config word with the direction bit, stream FFT_POINTS input beats into the core, then route the FFT_POINTS output beats back to the granted requester.
- Only one frame is in flight at a time.

---
 rtl/fft_core_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_fft_core_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_core_arbiter.sv
// fft_core_arbiter
// Shares one forward/inverse FFT core between two requesters. Port 0 issues
// forward transforms and port 1 issues inverse transforms. Each granted frame
// runs CFG -> LOAD -> UNLOAD, and only one frame is in flight at a time.
// The input and output beat paths are zero-latency muxes steered by the
// registered one-hot grant.

module fft_core_arbiter #(
    parameter int FFT_POINTS = 16,
    parameter int DATA_WIDTH = 24,
    parameter int OUT_WIDTH  = 64
) (
    input  logic                           clk,
    input  logic                           reset,

    // Requester arbitration
    input  logic [1:0]                     req,
    output logic [1:0]                     grant,

    // Requester input streams (lower half real, upper half imag)
    input  logic [1:0][2*DATA_WIDTH-1:0]   s_tdata,
    input  logic [1:0]                     s_tvalid,
    input  logic [1:0]                     s_tlast,
    output logic [1:0]                     s_tready,

    // Requester result streams (data broadcast, handshakes per requester)
    output logic [OUT_WIDTH-1:0]           m_tdata,
    output logic [1:0]                     m_tvalid,
    output logic [1:0]                     m_tlast,
    input  logic [1:0]                     m_tready,

    // FFT core configuration channel
    output logic [7:0]                     core_cfg_tdata,
    output logic                           core_cfg_tvalid,
    input  logic                           core_cfg_tready,

    // FFT core input channel
    output logic [2*DATA_WIDTH-1:0]        core_s_tdata,
    output logic                           core_s_tvalid,
    output logic                           core_s_tlast,
    input  logic                           core_s_tready,

    // FFT core output channel
    input  logic [OUT_WIDTH-1:0]           core_m_tdata,
    input  logic                           core_m_tvalid,
    input  logic                           core_m_tlast,
    output logic                           core_m_tready,

    // Status
    output logic                           busy,
    output logic                           err_tlast
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int              CNT_W    = $clog2(FFT_POINTS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_POINTS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CFG    = 2'd1;
    localparam logic [1:0] ST_LOAD   = 2'd2;
    localparam logic [1:0] ST_UNLOAD = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic             last_served;   // index of the requester served last
    logic [CNT_W-1:0] in_cnt;        // beats accepted into the core this frame
    logic [CNT_W:0]   out_cnt;       // beats returned this frame (debug only)

    // Selected requester index; grant is one-hot, so bit 1 names the port.
    logic sel;
    assign sel = grant[1];

    // Handshake qualifiers
    logic cfg_fire;
    logic in_fire;
    logic out_fire;
    logic in_last_beat;

    assign cfg_fire     = core_cfg_tvalid & core_cfg_tready;
    assign in_fire      = core_s_tvalid & core_s_tready;
    assign out_fire     = core_m_tvalid & core_m_tready;
    assign in_last_beat = (in_cnt == LAST_IDX);

    // Grant winner; on a tie, favour the requester not served last.
    logic [1:0] arb_grant;

    // Round-robin arbitration between the two requesters.
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        arb_grant = 2'b00;
        case (req)
            2'b01:   arb_grant = 2'b01;
            2'b10:   arb_grant = 2'b10;
            2'b11:   arb_grant = last_served ? 2'b01 : 2'b10;
            default: arb_grant = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------
    // Combinational datapath muxes
    // ------------------------------------------------------------------

    // Input path: only the granted requester sees core_s_tready during LOAD.
    always_comb begin
        s_tready      = 2'b00;
        core_s_tvalid = 1'b0;
        core_s_tlast  = 1'b0;
        core_s_tdata  = s_tdata[sel];
        if (state == ST_LOAD) begin
            core_s_tvalid = s_tvalid[sel];
            s_tready[sel] = core_s_tready;
            // tlast is generated locally so the core always sees a fixed-length frame
            core_s_tlast  = in_last_beat;
        end
    end

    // Output path: results are routed to the granted requester only during UNLOAD.
    always_comb begin
        m_tvalid      = 2'b00;
        m_tlast       = 2'b00;
        core_m_tready = 1'b0;
        if (state == ST_UNLOAD) begin
            m_tvalid[sel] = core_m_tvalid;
            m_tlast[sel]  = core_m_tlast;
            core_m_tready = m_tready[sel];
        end
    end

    assign m_tdata        = core_m_tdata;
    assign core_cfg_tdata = {7'b0000000, grant[0]};
    assign busy           = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Sequential control
    // ------------------------------------------------------------------

    // Frame sequencer: arbitration, config handshake and frame termination.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            grant           <= 2'b00;
            last_served     <= 1'b1;
            core_cfg_tvalid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        grant           <= arb_grant;
                        core_cfg_tvalid <= 1'b1;
                        state           <= ST_CFG;
                    end
                end
                ST_CFG: begin
                    if (cfg_fire) begin
                        core_cfg_tvalid <= 1'b0;
                        state           <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_fire && in_last_beat) begin
                        state <= ST_UNLOAD;
                    end
                end
                ST_UNLOAD: begin
                    // The core's tlast alone ends the frame.
                    if (out_fire && core_m_tlast) begin
                        state       <= ST_IDLE;
                        grant       <= 2'b00;
                        last_served <= sel;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Input beat counter, which sets the fixed frame length towards the core.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt <= '0;
        end else if (state == ST_LOAD && in_fire) begin
            if (in_last_beat) begin
                in_cnt <= '0;
            end else begin
                in_cnt <= in_cnt + 1'b1;
            end
        end
    end

    // Output beat counter, kept for debug visibility only.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt <= '0;
        end else if (state == ST_UNLOAD && out_fire) begin
            if (core_m_tlast) begin
                out_cnt <= '0;
            end else begin
                out_cnt <= out_cnt + 1'b1;
            end
        end
    end

    // One-cycle pulse when the requester's tlast disagrees with the fixed frame length.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_tlast <= 1'b0;
        end else begin
            err_tlast <= (state == ST_LOAD) && in_fire && (s_tlast[sel] != in_last_beat);
        end
    end

endmodule

// File: tb/tb_fft_core_arbiter.sv
// tb_fft_core_arbiter
// Directed bench for fft_core_arbiter. The bench plays both requesters and a
// simple stand-in FFT core. The core tags each output beat with the direction
// bit it was configured with, so data, routing and direction are all checked
// against values computed from the requester's own beat numbering.

module tb_fft_core_arbiter;

    localparam int N  = 16;
    localparam int DW = 24;
    localparam int OW = 64;

    logic                    clk;
    logic                    reset;
    logic [1:0]              req;
    logic [1:0]              grant;
    logic [1:0][2*DW-1:0]    s_tdata;
    logic [1:0]              s_tvalid;
    logic [1:0]              s_tlast;
    logic [1:0]              s_tready;
    logic [OW-1:0]           m_tdata;
    logic [1:0]              m_tvalid;
    logic [1:0]              m_tlast;
    logic [1:0]              m_tready;
    logic [7:0]              core_cfg_tdata;
    logic                    core_cfg_tvalid;
    logic                    core_cfg_tready;
    logic [2*DW-1:0]         core_s_tdata;
    logic                    core_s_tvalid;
    logic                    core_s_tlast;
    logic                    core_s_tready;
    logic [OW-1:0]           core_m_tdata;
    logic                    core_m_tvalid;
    logic                    core_m_tlast;
    logic                    core_m_tready;
    logic                    busy;
    logic                    err_tlast;

    fft_core_arbiter #(
        .FFT_POINTS (N),
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .grant           (grant),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tlast         (s_tlast),
        .s_tready        (s_tready),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tlast         (m_tlast),
        .m_tready        (m_tready),
        .core_cfg_tdata  (core_cfg_tdata),
        .core_cfg_tvalid (core_cfg_tvalid),
        .core_cfg_tready (core_cfg_tready),
        .core_s_tdata    (core_s_tdata),
        .core_s_tvalid   (core_s_tvalid),
        .core_s_tlast    (core_s_tlast),
        .core_s_tready   (core_s_tready),
        .core_m_tdata    (core_m_tdata),
        .core_m_tvalid   (core_m_tvalid),
        .core_m_tlast    (core_m_tlast),
        .core_m_tready   (core_m_tready),
        .busy            (busy),
        .err_tlast       (err_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench bookkeeping
    int          n_pass;
    int          n_total;
    int          sent [2];
    int          rx [2];
    logic [63:0] outq [$];
    logic [7:0]  cfg_log [$];
    logic [1:0]  grant_log [$];
    int          gap_log [$];
    int          frames_done;
    int          core_in_cnt;
    int          last_in_idx;
    int          err_cnt;
    int          err_at;
    int          idle_run;
    logic        core_dir;
    logic        loaded;
    logic        bp;
    logic        miss_last;
    int          bad_last_at;
    logic [1:0]  tx_en;
    logic [1:0]  prev_grant;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total += 1;
        assert (got === exp) n_pass += 1;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [23:0] real_of(int r, int k);
        return 24'(r << 20) | 24'(k & 32'h000F_FFFF);
    endfunction

    function automatic logic [47:0] beat(int r, int k);
        logic [23:0] re;
        re = real_of(r, k);
        return {~re, re};
    endfunction

    // Result beat k for requester r: direction bit, imag, zero pad, real.
    function automatic logic [63:0] exp_out(int r, int k);
        logic [23:0] re;
        logic        fwd;
        re  = real_of(r, k);
        fwd = (r == 0);
        return {7'b0000000, fwd, ~re, 8'h00, re};
    endfunction

    // Drive every bench-owned DUT input for the coming cycle.
    task automatic drive();
        int idx;
        for (int r = 0; r < 2; r++) begin
            idx         = sent[r] % N;
            s_tvalid[r] = tx_en[r];
            s_tdata[r]  = beat(r, sent[r]);
            s_tlast[r]  = miss_last ? 1'b0 : (idx == N - 1);
            if (bad_last_at >= 0 && idx == bad_last_at) s_tlast[r] = 1'b1;
        end
        core_cfg_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        core_s_tready   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        m_tready        = bp ? 2'($urandom_range(0, 3)) : 2'b11;
        core_m_tvalid   = loaded && (outq.size() > 0) && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
        core_m_tdata    = (outq.size() > 0) ? outq[0] : 64'h0;
        core_m_tlast    = (outq.size() == 1);
    endtask

    // One clock cycle: capture handshakes, step the edge, update models, redrive.
    task automatic tick();
        logic        cfg_f;
        logic        in_f;
        logic        out_f;
        logic [1:0]  s_f;
        logic [7:0]  cfg_d;
        logic [47:0] in_d;
        logic        in_last;
        logic [63:0] out_d;
        logic [1:0]  out_v;
        logic [1:0]  out_l;
        int          r;

        check("iso_s_tready", 2'(s_tready & ~grant), 0);
        check("iso_m_tvalid", 2'(m_tvalid & ~grant), 0);

        cfg_f   = core_cfg_tvalid & core_cfg_tready;
        cfg_d   = core_cfg_tdata;
        in_f    = core_s_tvalid & core_s_tready;
        in_d    = core_s_tdata;
        in_last = core_s_tlast;
        out_f   = core_m_tvalid & core_m_tready;
        out_d   = m_tdata;
        out_v   = m_tvalid;
        out_l   = m_tlast;
        s_f     = s_tvalid & s_tready;

        @(posedge clk);
        #1;

        if (reset) begin
            outq.delete();
            loaded      = 1'b0;
            core_in_cnt = 0;
            idle_run    = 0;
            prev_grant  = 2'b00;
            for (int k = 0; k < 2; k++) begin
                sent[k] = ((sent[k] + N - 1) / N) * N;
                rx[k]   = sent[k];
            end
        end else begin
            if (cfg_f) begin
                cfg_log.push_back(cfg_d);
                core_dir = cfg_d[0];
            end
            for (int k = 0; k < 2; k++) begin
                if (s_f[k]) sent[k]++;
            end
            if (in_f) begin
                check("core_s_tlast", in_last, core_in_cnt == N - 1);
                outq.push_back({7'b0000000, core_dir, in_d[47:24], 8'h00, in_d[23:0]});
                last_in_idx = core_in_cnt;
                core_in_cnt++;
                if (core_in_cnt == N) loaded = 1'b1;
            end
            if (out_f && outq.size() > 0) begin
                r = outq[0][20] ? 1 : 0;
                check("m_tvalid_route", out_v, 2'b01 << r);
                check("m_tdata", out_d, exp_out(r, rx[r]));
                check("m_tlast", out_l[r], (rx[r] % N) == N - 1);
                rx[r]++;
                void'(outq.pop_front());
                if (outq.size() == 0) begin
                    loaded      = 1'b0;
                    core_in_cnt = 0;
                    frames_done++;
                end
            end
            if (err_tlast) begin
                err_cnt++;
                err_at = last_in_idx;
            end
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                grant_log.push_back(grant);
                gap_log.push_back(idle_run);
            end
            idle_run   = busy ? 0 : idle_run + 1;
            prev_grant = grant;
        end
        drive();
        #1;
    endtask

    task automatic run_frames(input int n, input int budget);
        int target;
        int cyc;
        target = frames_done + n;
        cyc    = 0;
        while (frames_done < target && cyc < budget) begin
            tick();
            cyc++;
        end
        check("frames_done", frames_done, target);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, grant, 2'b00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, err_tlast, 1'b0);
        check({tag, "_cfg_tvalid"}, core_cfg_tvalid, 1'b0);
        check({tag, "_core_s_tvalid"}, core_s_tvalid, 1'b0);
        check({tag, "_s_tready"}, s_tready, 2'b00);
        check({tag, "_m_tvalid"}, m_tvalid, 2'b00);
        check({tag, "_core_m_tready"}, core_m_tready, 1'b0);
    endtask

    initial begin
        int rx0;
        int rx1;
        int cyc;

        n_pass      = 0;
        n_total     = 0;
        sent[0]     = 0;
        sent[1]     = 0;
        rx[0]       = 0;
        rx[1]       = 0;
        frames_done = 0;
        core_in_cnt = 0;
        last_in_idx = 0;
        err_cnt     = 0;
        err_at      = -1;
        idle_run    = 0;
        core_dir    = 1'b0;
        loaded      = 1'b0;
        bp          = 1'b0;
        miss_last   = 1'b0;
        bad_last_at = -1;
        tx_en       = 2'b00;
        prev_grant  = 2'b00;
        req         = 2'b00;
        reset       = 1'b1;
        drive();

        // ---- Reset state ----
        tick();
        tick();
        check_idle_outputs("reset");

        // ---- Single forward frame ----
        reset = 1'b0;
        req   = 2'b01;
        tx_en = 2'b01;
        tick();
        check("fwd_grant", grant, 2'b01);
        check("fwd_busy", busy, 1'b1);
        check("fwd_cfg_tvalid", core_cfg_tvalid, 1'b1);
        check("fwd_cfg_tdata", core_cfg_tdata, 8'h01);
        check("fwd_cfg_no_s_tready", s_tready, 2'b00);
        req = 2'b00;
        tick();
        check("fwd_cfg_count", cfg_log.size(), 1);
        check("fwd_cfg_word", cfg_log[0], 8'h01);
        run_frames(1, 200);
        check("fwd_end_grant", grant, 2'b00);
        check("fwd_end_busy", busy, 1'b0);
        check("fwd_rx_count", rx[0], 16);
        check("fwd_no_err", err_cnt, 0);
        tx_en = 2'b00;
        tick();

        // ---- Both requesting from reset: forward first, then alternate ----
        reset = 1'b1;
        tick();
        cfg_log.delete();
        grant_log.delete();
        gap_log.delete();
        reset = 1'b0;
        req   = 2'b11;
        tx_en = 2'b11;
        run_frames(4, 400);
        req   = 2'b00;
        tx_en = 2'b00;
        check("rr_grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_grant_%0d", i), grant_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr_cfg_%0d", i), cfg_log[i], (i % 2 == 0) ? 8'h01 : 8'h00);
        end
        for (int i = 1; i < 4; i++) begin
            check($sformatf("rr_gap_%0d", i), gap_log[i], 1);
        end
        check("rr_rx0", rx[0], 48);
        check("rr_rx1", rx[1], 32);
        tick();

        // ---- Random backpressure on an inverse frame ----
        bp    = 1'b1;
        rx1   = rx[1];
        req   = 2'b10;
        tx_en = 2'b10;
        tick();
        req = 2'b00;
        run_frames(1, 3000);
        bp    = 1'b0;
        tx_en = 2'b00;
        check("bp_grant", grant_log[grant_log.size() - 1], 2'b10);
        check("bp_rx1", rx[1] - rx1, 16);
        tick();

        // ---- Spurious tlast on beat 9 ----
        bad_last_at = 9;
        err_cnt     = 0;
        err_at      = -1;
        rx0         = rx[0];
        req         = 2'b01;
        tx_en       = 2'b01;
        tick();
        req = 2'b00;
        run_frames(1, 200);
        tx_en = 2'b00;
        check("early_last_err_cnt", err_cnt, 1);
        check("early_last_err_at", err_at, 9);
        check("early_last_rx", rx[0] - rx0, 16);
        bad_last_at = -1;
        tick();

        // ---- Missing tlast on beat 15 ----
        miss_last = 1'b1;
        err_cnt   = 0;
        err_at    = -1;
        rx0       = rx[0];
        req       = 2'b01;
        tx_en     = 2'b01;
        tick();
        req = 2'b00;
        run_frames(1, 200);
        tx_en = 2'b00;
        check("miss_last_err_cnt", err_cnt, 1);
        check("miss_last_err_at", err_at, 15);
        check("miss_last_rx", rx[0] - rx0, 16);
        miss_last = 1'b0;
        tick();

        // ---- Reset in the middle of LOAD at beat 7 ----
        err_cnt = 0;
        req     = 2'b01;
        tx_en   = 2'b01;
        tick();
        req = 2'b00;
        cyc = 0;
        while (core_in_cnt < 7 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("midload_reach_beat7", core_in_cnt, 7);
        check("midload_s_tready", s_tready, 2'b01);
        reset = 1'b1;
        tick();
        check_idle_outputs("midload_reset");
        reset = 1'b0;
        tx_en = 2'b10;
        req   = 2'b10;
        rx1   = rx[1];
        tick();
        check("post_reset_grant", grant, 2'b10);
        check("post_reset_cfg_tdata", core_cfg_tdata, 8'h00);
        req = 2'b00;
        run_frames(1, 200);
        tx_en = 2'b00;
        check("post_reset_rx1", rx[1] - rx1, 16);
        check("post_reset_no_err", err_cnt, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
